// File: rtl/output_packetizer_pkg.sv
// Shared types and constants for the output packetizer.
// Header layout, FSM encoding and segment data-type codes.
package output_packetizer_pkg;

  localparam int WORD_W  = 32;
  localparam int DTYPE_W = 4;
  localparam int LEN_W   = 16;
  localparam int CNT_W   = 15;

  localparam int HDR_DTYPE_LSB = 28;
  localparam int HDR_RSVD_BIT  = 27;
  localparam int HDR_EOT_BIT   = 26;
  localparam int HDR_EOI_BIT   = 25;
  localparam int HDR_LAST_BIT  = 24;
  localparam int HDR_MARK_BIT  = 16;
  localparam int HDR_LEN_LSB   = 0;

  localparam logic [DTYPE_W-1:0] DT_RAW   = 4'h0;
  localparam logic [DTYPE_W-1:0] DT_CTRL  = 4'h1;
  localparam logic [DTYPE_W-1:0] DT_IMAGE = 4'h2;
  localparam logic [DTYPE_W-1:0] DT_AUDIO = 4'h3;
  localparam logic [DTYPE_W-1:0] DT_META  = 4'h4;
  localparam logic [DTYPE_W-1:0] DT_TEXT  = 4'h5;
  localparam logic [DTYPE_W-1:0] DT_BLOB  = 4'h6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef struct packed {
    logic [DTYPE_W-1:0] dtype;
    logic               eot;
    logic               eoi;
    logic               last;
    logic [LEN_W-1:0]   length;
  } seg_desc_t;

  // 17-bit sum so 65535 rounds up to 16384 without wrapping
  function automatic logic [CNT_W-1:0] word_count(
    input logic [LEN_W-1:0] len
  );
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + 17'd3;
    return sum[LEN_W:2];
  endfunction

  function automatic logic [WORD_W-1:0] tail_mask(
    input logic [1:0] rem
  );
    logic [WORD_W-1:0] m;
    m = '1;
    unique case (1'b1)
      (rem == 2'd1): m = 32'hFF00_0000;
      (rem == 2'd2): m = 32'hFFFF_0000;
      (rem == 2'd3): m = 32'hFFFF_FF00;
      default:       m = '1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/output_packetizer_header_encoder.sv
// Packs a registered segment descriptor into the 32-bit header word.
// Field placement comes from the shared package offsets.
module header_encoder
  import output_packetizer_pkg::*;
(
  input  seg_desc_t           desc_i,
  output logic [WORD_W-1:0]   hdr_o
);

  always_comb begin
    hdr_o = '0;
    hdr_o[HDR_DTYPE_LSB +: DTYPE_W] = desc_i.dtype;
    hdr_o[HDR_RSVD_BIT]             = 1'b0;
    hdr_o[HDR_EOT_BIT]              = desc_i.eot;
    hdr_o[HDR_EOI_BIT]              = desc_i.eoi;
    hdr_o[HDR_LAST_BIT]             = desc_i.last;
    hdr_o[HDR_MARK_BIT]             = 1'b1;
    hdr_o[HDR_LEN_LSB +: LEN_W]     = desc_i.length;
  end

endmodule

// File: rtl/output_packetizer.sv
// Segment packetizer: header word then pass-through payload words.
// OUTPUT_PACKETIZER_PAD_EN zeroes unused bytes of the final word.
module output_packetizer
  import output_packetizer_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                seg_valid,
  output logic                seg_ready,
  input  logic [DTYPE_W-1:0]  seg_dtype,
  input  logic                seg_eot,
  input  logic                seg_eoi,
  input  logic                seg_last,
  input  logic [LEN_W-1:0]    seg_length,
  input  logic [WORD_W-1:0]   din_data,
  input  logic                din_valid,
  output logic                din_ready,
  output logic [WORD_W-1:0]   dout_data,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                busy
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  seg_desc_t         desc_q, desc_d;
  logic [WORD_W-1:0] hdr_w;
  logic [WORD_W-1:0] data_w;

  header_encoder u_hdr (
    .desc_i (desc_q),
    .hdr_o  (hdr_w)
  );

`ifdef OUTPUT_PACKETIZER_PAD_EN
  logic is_tail;

  assign is_tail = (cnt_q == 15'd1) &&
                   (desc_q.length[1:0] != 2'd0);

  always_comb begin
    data_w = din_data;
    if (is_tail) begin
      data_w = din_data & tail_mask(desc_q.length[1:0]);
    end
  end
`else
  assign data_w = din_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      desc_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      desc_q  <= desc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    desc_d     = desc_q;
    seg_ready  = 1'b0;
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    dout_data  = '0;
    unique case (state_q)
      ST_IDLE: begin
        seg_ready = 1'b1;
        if (seg_valid) begin
          desc_d.dtype  = seg_dtype;
          desc_d.eot    = seg_eot;
          desc_d.eoi    = seg_eoi;
          desc_d.last   = seg_last;
          desc_d.length = seg_length;
          cnt_d         = word_count(seg_length);
          state_d       = ST_HDR;
        end
      end
      ST_HDR: begin
        dout_valid = 1'b1;
        dout_data  = hdr_w;
        if (dout_ready) begin
          state_d = (cnt_q != '0) ? ST_DATA : ST_IDLE;
        end
      end
      ST_DATA: begin
        dout_valid = din_valid;
        din_ready  = dout_ready;
        dout_data  = data_w;
        if (din_valid && dout_ready) begin
          cnt_d = cnt_q - 15'd1;
          if (cnt_q == 15'd1) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_output_packetizer.sv
// Randomized self-checking bench for output_packetizer.
// Honours OUTPUT_PACKETIZER_PAD_EN for the expected tail word.
module tb_output_packetizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seg_valid;
  logic        seg_ready;
  logic [3:0]  seg_dtype;
  logic        seg_eot;
  logic        seg_eoi;
  logic        seg_last;
  logic [15:0] seg_length;
  logic [31:0] din_data;
  logic        din_valid;
  logic        din_ready;
  logic [31:0] dout_data;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int din_pct = 100;
  int rdy_pct = 100;
  int rdy_lo  = 0;
  int viol    = 0;
  int drdy_n  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] din_q[$];
  logic [31:0] fix_q[$];
  logic [31:0] obs_q[$];
  int          hs_cyc[$];

  output_packetizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_valid  (seg_valid),
    .seg_ready  (seg_ready),
    .seg_dtype  (seg_dtype),
    .seg_eot    (seg_eot),
    .seg_eoi    (seg_eoi),
    .seg_last   (seg_last),
    .seg_length (seg_length),
    .din_data   (din_data),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout_data  (dout_data),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    #1;
    if (din_q.size() > 0 &&
        int'($urandom_range(99)) < din_pct) begin
      din_valid = 1'b1;
      din_data  = din_q[0];
    end else begin
      din_valid = 1'b0;
      din_data  = $urandom;
    end
    if (rdy_lo > 0) begin
      dout_ready = 1'b0;
      rdy_lo--;
    end else begin
      dout_ready = int'($urandom_range(99)) < rdy_pct;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (din_ready && !dout_ready) viol++;
      if (seg_ready == busy) viol++;
      if (!busy && (dout_valid || din_ready)) viol++;
      if (!busy && dout_data != 32'h0) viol++;
      if (din_ready) drdy_n++;
      if (din_valid && din_ready && din_q.size() > 0)
        void'(din_q.pop_front());
      if (dout_valid && dout_ready) begin
        chk("out_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0)
          chk("dout", dout_data, exp_q.pop_front());
        obs_q.push_back(dout_data);
        hs_cyc.push_back(cyc);
      end
    end
  end

  function automatic logic [31:0] pad(input logic [31:0] w,
                                      input int len);
    logic [31:0] ones;
    int rem;
    ones = '1;
    rem  = len % 4;
`ifdef OUTPUT_PACKETIZER_PAD_EN
    if (rem != 0) return w & ~(ones >> (8 * rem));
`endif
    return w;
  endfunction

  task automatic queue_seg(input logic [3:0] dt,
                           input logic eot, eoi, last,
                           input logic [15:0] len,
                           output logic [31:0] hdr);
    int n;
    logic [31:0] w;
    hdr = {dt, 1'b0, eot, eoi, last, 7'b0, 1'b1, len};
    exp_q.push_back(hdr);
    n = (int'(len) + 3) / 4;
    for (int i = 0; i < n; i++) begin
      w = (fix_q.size() > 0) ? fix_q.pop_front() : $urandom;
      din_q.push_back(w);
      exp_q.push_back((i == n - 1) ? pad(w, int'(len)) : w);
    end
  endtask

  task automatic set_fields(input logic [3:0] dt,
                            input logic eot, eoi, last,
                            input logic [15:0] len);
    seg_dtype  = dt;
    seg_eot    = eot;
    seg_eoi    = eoi;
    seg_last   = last;
    seg_length = len;
  endtask

  task automatic drive_seg(input logic [3:0] dt,
                           input logic eot, eoi, last,
                           input logic [15:0] len,
                           input logic [31:0] hdr,
                           input bit stall);
    @(posedge clk);
    #1;
    set_fields(dt, eot, eoi, last, len);
    seg_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (seg_ready) break;
    end
    chk("accept", 32'(seg_ready), 32'd1);
    if (stall) rdy_lo = 3;
    @(posedge clk);
    #1 seg_valid = 1'b0;
    @(negedge clk);
    chk("hdr_lat", 32'(dout_valid), 32'd1);
    chk("hdr_word", dout_data, hdr);
    if (stall) begin
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        chk("hdr_hold_v", 32'(dout_valid), 32'd1);
        chk("hdr_hold_d", dout_data, hdr);
      end
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    chk("idle", 32'(busy), 32'd0);
  endtask

  task automatic run_seg(input logic [3:0] dt,
                         input logic eot, eoi, last,
                         input logic [15:0] len,
                         input bit stall);
    logic [31:0] hdr;
    int h0;
    h0 = hs_cyc.size();
    queue_seg(dt, eot, eoi, last, len, hdr);
    drive_seg(dt, eot, eoi, last, len, hdr, stall);
    wait_done();
    chk("nwords", 32'(hs_cyc.size() - h0 - 1),
        32'((int'(len) + 3) / 4));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h1, h2, tail;
    int o0, d0, h0;
    rst_n      = 1'b0;
    seg_valid  = 1'b0;
    din_valid  = 1'b0;
    din_data   = '0;
    dout_ready = 1'b0;
    set_fields(4'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    #1;
    chk("rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("rst_din_ready", 32'(din_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dout_data", dout_data, 32'h0);
    #22 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_seg_ready", 32'(seg_ready), 32'd1);

    o0 = obs_q.size();
    run_seg(4'h6, 1'b1, 1'b0, 1'b1, 16'd8, 1'b0);
    chk("ex1_hdr", obs_q[o0], 32'h6501_0008);

    o0 = obs_q.size();
    d0 = drdy_n;
    run_seg(4'h1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    chk("ex2_hdr", obs_q[o0], 32'h1001_0000);
    chk("ex2_no_din_ready", 32'(drdy_n - d0), 32'd0);

    o0 = obs_q.size();
    fix_q.push_back(32'hAABB_CCDD);
    fix_q.push_back(32'h1122_3344);
    run_seg(4'h2, 1'b0, 1'b1, 1'b0, 16'd5, 1'b0);
`ifdef OUTPUT_PACKETIZER_PAD_EN
    tail = 32'h1100_0000;
`else
    tail = 32'h1122_3344;
`endif
    chk("ex3_w0", obs_q[o0+1], 32'hAABB_CCDD);
    chk("ex3_tail", obs_q[o0+2], tail);

    din_pct = 60;
    rdy_pct = 60;
    run_seg(4'h3, 1'b0, 1'b0, 1'b1, 16'd37, 1'b1);

    for (int k = 0; k < 16; k++) begin
      din_pct = 30 + int'($urandom_range(70));
      rdy_pct = 30 + int'($urandom_range(70));
      run_seg(4'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 16'($urandom_range(70)),
              1'($urandom));
    end

    din_pct = 100;
    rdy_pct = 100;
    run_seg(4'h4, 1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b0);

    h0 = hs_cyc.size();
    queue_seg(4'h5, 1'b0, 1'b0, 1'b0, 16'd16, h1);
    drive_seg(4'h5, 1'b0, 1'b0, 1'b0, 16'd16, h1, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (hs_cyc.size() - h0 >= 3) break;
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_handshakes", 32'(hs_cyc.size() - h0), 32'd3);
    chk("mid_rst_dout_valid", 32'(dout_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_din_ready", 32'(din_ready), 32'd0);
    exp_q.delete();
    din_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_seg_ready", 32'(seg_ready), 32'd1);
    chk("post_rst_dout_valid", 32'(dout_valid), 32'd0);
    run_seg(4'h5, 1'b1, 1'b0, 1'b0, 16'd16, 1'b0);

    h0 = hs_cyc.size();
    queue_seg(4'h2, 1'b0, 1'b0, 1'b0, 16'd4, h1);
    queue_seg(4'h3, 1'b0, 1'b0, 1'b1, 16'd4, h2);
    @(posedge clk);
    #1;
    set_fields(4'h2, 1'b0, 1'b0, 1'b0, 16'd4);
    seg_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (seg_ready) break;
    end
    @(posedge clk);
    #1 set_fields(4'h3, 1'b0, 1'b0, 1'b1, 16'd4);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (seg_ready && hs_cyc.size() - h0 >= 2) break;
    end
    chk("b2b_first_done", 32'(hs_cyc.size() - h0), 32'd2);
    @(posedge clk);
    #1 seg_valid = 1'b0;
    wait_done();
    chk("b2b_count", 32'(hs_cyc.size() - h0), 32'd4);
    if (hs_cyc.size() - h0 >= 4) begin
      chk("b2b_gap", 32'(hs_cyc[h0+2] - hs_cyc[h0+1]), 32'd2);
      chk("b2b_hdr2", obs_q[obs_q.size()-2], h2);
    end

    chk("protocol_viol", 32'(viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
